// File: rtl/aurora_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aurora_pkg : CHDR header field helpers and demux FSM state encoding  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package aurora_pkg;

  localparam int DSTEPID_LSB = 0;
  localparam int DSTEPID_W   = 16;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } demux_state_t;

  function automatic logic [DSTEPID_W-1:0] chdr_get_dst_epid(input logic [63:0] hdr);
    return hdr[DSTEPID_LSB +: DSTEPID_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_pipe_reg : one-entry AXIS register slice, loads when free or    |
// |                 when the held beat leaves in the same cycle          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module axis_pipe_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_valid,
  output logic              o_can_load
);

  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_valid;

  assign o_can_load = !r_valid || i_ready;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_valid    = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/chdr_channel_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chdr_channel_demux : routes CHDR packets to per-channel streams by   |
// |                      DstEPID - CHANNEL_OFFSET, drops out-of-range    |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module chdr_channel_demux
  import aurora_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int CHDR_W         = 256,
  parameter int CHANNEL_OFFSET = 0,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHDR_W-1:0]           in_tdata,
  input  logic                        in_tvalid,
  input  logic                        in_tlast,
  output logic                        in_tready,
  output logic [NUM_PORTS*CHDR_W-1:0] out_tdata,
  output logic [NUM_PORTS-1:0]        out_tvalid,
  output logic [NUM_PORTS-1:0]        out_tlast,
  input  logic [NUM_PORTS-1:0]        out_tready,
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int c_SEL_W = 5;

  demux_state_t          r_state;
  logic [c_SEL_W-1:0]    r_sel;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic [DSTEPID_W-1:0]  w_dst;
  logic [DSTEPID_W-1:0]  w_chan;
  logic                  w_hdr_ok;
  logic                  w_hdr_can;
  logic                  w_sel_can;
  logic                  w_hs;
  logic [NUM_PORTS-1:0]  w_can_load;
  logic [NUM_PORTS-1:0]  w_load;

  // Unsigned 16-bit subtraction: EPIDs below the offset wrap to large values and drop.
  assign w_dst    = chdr_get_dst_epid(in_tdata[63:0]);
  assign w_chan   = w_dst - DSTEPID_W'(CHANNEL_OFFSET);
  assign w_hdr_ok = (w_chan < DSTEPID_W'(NUM_PORTS));

  always_comb begin
    w_hdr_can = 1'b0;
    w_sel_can = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_chan == DSTEPID_W'(p)) w_hdr_can = w_can_load[p];
      if (r_sel == c_SEL_W'(p))    w_sel_can = w_can_load[p];
    end
  end

  always_comb begin
    in_tready = 1'b0;
    case (r_state)
      ST_HEAD: in_tready = w_hdr_ok ? w_hdr_can : 1'b1;
      ST_PASS: in_tready = w_sel_can;
      ST_DROP: in_tready = 1'b1;
      default: in_tready = 1'b0;
    endcase
  end

  assign w_hs = in_tvalid && in_tready;

  always_comb begin
    w_load = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_load[p] = w_hs &&
                  (((r_state == ST_HEAD) && w_hdr_ok && (w_chan == DSTEPID_W'(p))) ||
                   ((r_state == ST_PASS) && (r_sel == c_SEL_W'(p))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HEAD;
      r_sel        <= '0;
      r_drop_count <= '0;
    end else if (w_hs) begin
      case (r_state)
        ST_HEAD: begin
          if (w_hdr_ok) begin
            r_sel   <= w_chan[c_SEL_W-1:0];
            r_state <= in_tlast ? ST_HEAD : ST_PASS;
          end else begin
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
            r_state <= in_tlast ? ST_HEAD : ST_DROP;
          end
        end
        ST_PASS: if (in_tlast) r_state <= ST_HEAD;
        ST_DROP: if (in_tlast) r_state <= ST_HEAD;
        default: r_state <= ST_HEAD;
      endcase
    end
  end

  assign drop_count = r_drop_count;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      axis_pipe_reg #(
        .DATA_W (CHDR_W)
      ) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load[p]),
        .i_data     (in_tdata),
        .i_last     (in_tlast),
        .i_ready    (out_tready[p]),
        .o_data     (out_tdata[p*CHDR_W +: CHDR_W]),
        .o_last     (out_tlast[p]),
        .o_valid    (out_tvalid[p]),
        .o_can_load (w_can_load[p])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chdr_channel_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chdr_channel_demux : scoreboard bench with per-port expect queues |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_chdr_channel_demux;

  localparam int NP   = 2;
  localparam int W    = 64;
  localparam int OFS  = 4;
  localparam int DW   = 2;
  localparam int DMAX = (1 << DW) - 1;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     in_tdata = '0;
  logic             in_tvalid = 1'b0;
  logic             in_tlast = 1'b0;
  logic             in_tready;
  logic [NP*W-1:0]  out_tdata;
  logic [NP-1:0]    out_tvalid;
  logic [NP-1:0]    out_tlast;
  logic [NP-1:0]    out_tready;
  logic [DW-1:0]    drop_count;

  logic             rand_rdy = 1'b0;
  logic [NP-1:0]    dir_rdy = '1;
  logic [NP-1:0]    r_rand = '1;

  beat_t            exp_q [NP][$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               model_drop = 0;
  int               cyc = 0;

  chdr_channel_demux #(
    .NUM_PORTS      (NP),
    .CHDR_W         (W),
    .CHANNEL_OFFSET (OFS),
    .DROP_CNT_W     (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign out_tready = rand_rdy ? r_rand : dir_rdy;
  always @(posedge clk) begin
    #1;
    r_rand = NP'($urandom);
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat leaves a port when valid and ready are both high at the edge.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst_n && out_tvalid[p] && out_tready[p]) begin
        if (exp_q[p].size() == 0) begin
          check($sformatf("unexpected_beat_port%0d", p), {out_tlast[p], out_tdata[p*W +: W]}, '0);
        end else begin
          beat_t e;
          e = exp_q[p].pop_front();
          check($sformatf("port%0d_beat", p), {out_tlast[p], out_tdata[p*W +: W]}, {e.l, e.d});
        end
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l, output int waits);
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    waits     = 0;
    forever begin
      @(negedge clk);
      if (in_tready) break;
      waits++;
      if (waits > 2000) begin
        check("in_tready_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  function automatic logic [W-1:0] mk_beat(input int dst, input bit hdr);
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    if (hdr) v[15:0] = 16'(dst);
    return v;
  endfunction

  // Reference routing: whole packet goes to port (dst-OFS) mod 2^16 if in range.
  task automatic send_pkt(input int dst, input int len, output int total_waits);
    beat_t b [$];
    int    chan;
    int    w;
    total_waits = 0;
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.d = mk_beat(dst, i == 0);
      x.l = (i == len - 1);
      b.push_back(x);
    end
    chan = (dst - OFS) & 16'hFFFF;
    if (chan < NP) begin
      foreach (b[i]) exp_q[chan].push_back(b[i]);
    end else begin
      model_drop = (model_drop >= DMAX) ? DMAX : model_drop + 1;
    end
    foreach (b[i]) begin
      send_beat(b[i].d, b[i].l, w);
      total_waits += w;
    end
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    int w;
    int t0;
    beat_t x;

    #23;
    check("reset_out_tvalid", W'(out_tvalid), '0);
    check("reset_out_tlast", W'(out_tlast), '0);
    check("reset_out_tdata", out_tdata[NP*W-1 -: W] | out_tdata[W-1:0], '0);
    check("reset_drop_count", W'(drop_count), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat packet to port 1 with one-cycle latency
    for (int i = 0; i < 3; i++) begin
      x.d = mk_beat(5, i == 0);
      x.l = (i == 2);
      exp_q[1].push_back(x);
      send_beat(x.d, x.l, w);
      check("t1_latency_valid", W'(out_tvalid), W'(2'b10));
    end
    @(posedge clk); #1;

    // back-to-back 2-beat packets without bubbles
    t0 = cyc;
    send_pkt(4, 2, w);
    send_pkt(5, 2, w);
    send_pkt(4, 2, w);
    check("t2_no_bubble_cycles", W'(cyc - t0), W'(6));
    @(posedge clk); #1;

    // out-of-range packet is swallowed at full rate
    send_pkt(9, 4, w);
    check("t3_drop_no_stall", W'(w), '0);
    check("t3_drop_count", W'(drop_count), W'(model_drop));
    send_pkt(4, 2, w);
    @(posedge clk); #1;

    // backpressure on port 1
    dir_rdy = 2'b01;
    x.d = mk_beat(5, 1'b1); x.l = 1'b0; exp_q[1].push_back(x);
    send_beat(x.d, x.l, w);
    x.d = mk_beat(5, 1'b0); x.l = 1'b0; exp_q[1].push_back(x);
    in_tdata = x.d; in_tlast = x.l; in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_in_tready", W'(in_tready), '0);
      check("t4_port0_idle", W'(out_tvalid[0]), '0);
    end
    @(posedge clk); #1;
    dir_rdy = 2'b11;
    send_beat(x.d, x.l, w);
    x.d = mk_beat(5, 1'b0); x.l = 1'b1; exp_q[1].push_back(x);
    send_beat(x.d, x.l, w);
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset during the second beat
    x.d = mk_beat(4, 1'b1); x.l = 1'b0; exp_q[0].push_back(x);
    send_beat(x.d, x.l, w);
    in_tdata = mk_beat(4, 1'b0); in_tlast = 1'b0; in_tvalid = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_tvalid = 1'b0;
    #1;
    check("rst_mid_out_tvalid", W'(out_tvalid), '0);
    check("rst_mid_drop_count", W'(drop_count), '0);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    model_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(4, 3, w);
    repeat (2) @(posedge clk);
    #1;
    check("rst_after_q0_drained", W'(exp_q[0].size()), '0);

    // saturating drop counter
    for (int i = 0; i < 5; i++) begin
      send_pkt(9, 1, w);
      check($sformatf("t5_drop_sat_%0d", i), W'(drop_count), W'(sat_exp[i]));
    end

    // randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      send_pkt(int'($urandom_range(7, 3)), int'($urandom_range(4, 1)), w);
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    dir_rdy = 2'b11;
    t0 = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t0 < 200) begin
      @(posedge clk); #1;
      t0++;
    end
    check("final_q0_empty", W'(exp_q[0].size()), '0);
    check("final_q1_empty", W'(exp_q[1].size()), '0);
    check("final_drop_count", W'(drop_count), W'(model_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
